rf_scoreboard: RTL

Parametrised register-file scoreboard for CPU simulation and on-board self-test. It holds a table of expected register values with per-entry check enables, and counts cycles from `start` until the CPU raises `halt`. It then scans the register file through a read port, compares every enabled entry and reports pass/fail, the error count and the first mismatch. It sits beside the CPU in the top level and taps the register file's debug read port.

---
 rtl/rf_scoreboard.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: times a CPU run from start to halt, then scans the RF against an expected table.
// Optional watchdog that ends a run without halt: define RF_SCOREBOARD_TIMEOUT_EN.
module rf_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CW    = 24,
    localparam int AW   = $clog2(NREGS),
    localparam int EW   = $clog2(NREGS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic [CW-1:0]   timeout_limit,
    input  logic            exp_we,
    input  logic [AW-1:0]   exp_addr,
    input  logic [XLEN-1:0] exp_data,
    input  logic            exp_chk,
    output logic [AW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timed_out,
    output logic [EW-1:0]   err_count,
    output logic [AW-1:0]   first_err_idx,
    output logic [XLEN-1:0] first_err_got,
    output logic [CW-1:0]   cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_t;

    state_t          state_q;
    logic            busy_q, done_q, pass_q, timed_out_q;
    logic [EW-1:0]   err_count_q;
    logic [AW-1:0]   first_err_idx_q, idx_q;
    logic [XLEN-1:0] first_err_got_q;
    logic [CW-1:0]   cycle_count_q;

    logic [XLEN-1:0] exp_mem [NREGS];
    logic [NREGS-1:0] chk_q;

    logic            table_we;
    logic [CW-1:0]   cycle_count_d;
    logic [EW-1:0]   err_count_d;
    logic            mismatch, last_idx, wd_hit;

    assign table_we      = exp_we && !busy_q;
    assign cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CW'(1);
    assign mismatch      = chk_q[idx_q] && (rf_rdata != exp_mem[idx_q]);
    assign err_count_d   = err_count_q + EW'(mismatch);
    assign last_idx      = (idx_q == AW'(NREGS - 1));

`ifdef RF_SCOREBOARD_TIMEOUT_EN
    // Fires on the edge at which the count would reach the limit.
    assign wd_hit = (timeout_limit != '0) && (cycle_count_d == timeout_limit);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_limit;
    assign wd_hit         = 1'b0;
`endif

    // Table data is deliberately not reset; only the check enables are.
    always_ff @(posedge clk) begin
        if (table_we) exp_mem[exp_addr] <= exp_data;
    end

    always_ff @(posedge clk) begin
        if (rst)           chk_q <= '0;
        else if (table_we) chk_q[exp_addr] <= exp_chk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            timed_out_q     <= 1'b0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_got_q <= '0;
            cycle_count_q   <= '0;
            idx_q           <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q         <= S_RUN;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                        timed_out_q     <= 1'b0;
                        err_count_q     <= '0;
                        first_err_idx_q <= '0;
                        first_err_got_q <= '0;
                        cycle_count_q   <= '0;
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cycle_count_d;
                    if (halt) begin
                        state_q <= S_SCAN;
                        idx_q   <= '0;
                    end else if (wd_hit) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        timed_out_q <= 1'b1;
                        pass_q      <= 1'b0;
                    end
                end
                S_SCAN: begin
                    err_count_q <= err_count_d;
                    if (mismatch && (err_count_q == '0)) begin
                        first_err_idx_q <= idx_q;
                        first_err_got_q <= rf_rdata;
                    end
                    if (last_idx) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                        pass_q  <= (err_count_d == '0) && !timed_out_q;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rf_raddr      = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timed_out     = timed_out_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_got = first_err_got_q;
    assign cycle_count   = cycle_count_q;

endmodule
